booth_mult: RTL and testbench



---
 rtl/booth_mult_pkg.sv | 17 +
 rtl/booth_mult_step.sv | 33 +++
 rtl/booth_mult.sv | 121 ++++++++++++
 tb/tb_booth_mult.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states,
// default sizing and the Booth recoding pairs {q[0], q_m1}.
package booth_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_step.sv
// One radix-2 Booth iteration, purely combinational: conditional
// add/subtract of the multiplicand into the accumulator, then an
// arithmetic right shift of {acc, q, q_m1} by one bit.
module booth_mult_step
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic signed [WIDTH:0]   acc_i,
  input  logic        [WIDTH-1:0] q_i,
  input  logic                    q_m1_i,
  input  logic signed [WIDTH:0]   mcand_i,
  output logic signed [WIDTH:0]   acc_o,
  output logic        [WIDTH-1:0] q_o,
  output logic                    q_m1_o
);

  logic signed [WIDTH:0] sum;

  // Booth recode on {q[0], q_m1}, then shift the whole register pair right.
  always_comb begin
    sum = acc_i;
    case ({q_i[0], q_m1_i})
      BOOTH_ADD: sum = acc_i + mcand_i;
      BOOTH_SUB: sum = acc_i - mcand_i;
      default:   sum = acc_i;
    endcase
    acc_o  = sum >>> 1;
    q_o    = {sum[0], q_i[WIDTH-1:1]};
    q_m1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier with a
// start/done handshake. Result {HI, LO} is the full two's-complement
// product, updated only on completion and held until the next one.
// Optional macro MULT_ZERO_BYPASS_EN: a zero operand at start skips the
// iterations and completes with a zero product in one cycle.
module booth_mult
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mult_in,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_out
);

  state_t                  state_q, state_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [WIDTH:0]   mcand_q, mcand_d;
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic        [WIDTH-1:0] qr_q, qr_d;
  logic                    q_m1_q, q_m1_d;
  logic        [WIDTH-1:0] hi_q, hi_d;
  logic        [WIDTH-1:0] lo_q, lo_d;

  logic signed [WIDTH:0]   step_acc;
  logic        [WIDTH-1:0] step_q;
  logic                    step_q_m1;

  booth_mult_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .q_i     (qr_q),
    .q_m1_i  (q_m1_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .q_o     (step_q),
    .q_m1_o  (step_q_m1)
  );

  // Next-state logic: operand capture on start, one Booth step per RUN cycle,
  // result commit on the last iteration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    q_m1_d  = q_m1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (mult_in) begin
          mcand_d = {A[WIDTH-1], A};
          acc_d   = '0;
          qr_d    = B;
          q_m1_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef MULT_ZERO_BYPASS_EN
          if ((A == '0) || (B == '0)) begin
            hi_d    = '0;
            lo_d    = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        acc_d  = step_acc;
        qr_d   = step_q;
        q_m1_d = step_q_m1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          hi_d    = step_acc[WIDTH-1:0];
          lo_d    = step_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      q_m1_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      q_m1_q  <= q_m1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign mult_out = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: a cycle-level behavioural model
// (countdown + signed product) compared every cycle, plus directed
// operations with hand-computed products and latencies.
module tb_booth_mult;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] A, B;
  logic             mult_in;
  logic [WIDTH-1:0] HI, LO;
  logic             mult_out;

  int passed = 0;
  int total  = 0;

  booth_mult #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .mult_in  (mult_in),
    .HI       (HI),
    .LO       (LO),
    .mult_out (mult_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit bypass_en();
`ifdef MULT_ZERO_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: remaining-cycle countdown and a pending product.
  int          m_rem  = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_res  = '0;

  always begin
    @(posedge clock);
    if (reset) begin
      m_rem = 0; m_done = 1'b0; m_res = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_res  = m_prod;
        m_done = 1'b1;
      end
    end else if (mult_in) begin
      m_prod = longint'($signed(A)) * longint'($signed(B));
      if (bypass_en() && (A == '0 || B == '0)) begin
        m_res  = '0;
        m_done = 1'b1;
      end else begin
        m_rem = WIDTH;
      end
    end
    #1;
    check("model_hilo", {HI, LO}, m_res);
    check("model_done", 64'(mult_out), 64'(m_done));
  end

  // Start one operation, optionally disturb it at cycle 10, and check the
  // literal result, latency and single-cycle done pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input bit disturb, input string name);
    int cycles;
    @(negedge clock);
    A = a; B = b; mult_in = 1'b1;
    @(negedge clock);
    mult_in = 1'b0;
    cycles = 0;
    while (!mult_out && cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (disturb && cycles == 10) begin
        mult_in = 1'b1; A = 32'd99; B = 32'd77;
      end
      if (disturb && cycles == 11) mult_in = 1'b0;
    end
    check({name, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({name, "_hi"}, 64'(HI), 64'(exp_hi));
    check({name, "_lo"}, 64'(LO), 64'(exp_lo));
    @(negedge clock);
    check({name, "_done_one_cycle"}, 64'(mult_out), 64'd0);
    check({name, "_hold"}, {HI, LO}, {exp_hi, exp_lo});
  endtask

  initial begin
    reset = 1'b1; mult_in = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clock);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_done", 64'(mult_out), 64'd0);
    reset = 1'b0;

    run_op(32'd7, 32'd3, 32'h0, 32'h15, 32, 1'b0, "7x3");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32, 1'b0, "m1xm1");
    run_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 32, 1'b0, "minxmin");
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32, 1'b0, "maxxm1");
    run_op(32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32, 1'b0, "m7x3");
    run_op(32'd5, 32'd6, 32'h0, 32'd30, 32, 1'b1, "5x6_disturbed");

    // Abort mid-operation: result clears at once, no done pulse follows.
    @(negedge clock);
    A = 32'd12345; B = 32'd678; mult_in = 1'b1;
    @(negedge clock);
    mult_in = 1'b0;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    check("abort_done", 64'(mult_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    begin
      int pulses = 0;
      repeat (40) begin
        @(negedge clock);
        if (mult_out) pulses++;
      end
      check("abort_no_done", 64'(pulses), 64'd0);
    end

    run_op(32'd2, 32'd2, 32'h0, 32'd4, 32, 1'b0, "2x2_after_abort");
    run_op(32'd0, 32'h1234, 32'h0, 32'h0, bypass_en() ? 0 : 32, 1'b0, "zero_a");

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
